// File: rtl/receiver_if.sv
// Receiver bus: serial line, frame format and receive-FIFO side signals.
interface receiver_if;
    logic       brgen;
    logic       enable;
    logic       rx;
    logic       size;
    logic       stop2;
    logic [1:0] parity;
    logic       full;
    logic       clr_ovr;
    logic [9:0] data;
    logic       wr_en;
    logic       overrun;
    logic       busy;

    modport master (
        output brgen, enable, rx, size, stop2, parity, full, clr_ovr,
        input  data, wr_en, overrun, busy
    );

    modport slave (
        input  brgen, enable, rx, size, stop2, parity, full, clr_ovr,
        output data, wr_en, overrun, busy
    );
endinterface

// File: rtl/receiver.sv
// UART receive engine: 16x oversampling, start/data/parity/stop recovery,
// pushes {fe, pe, char} into the receive FIFO and flags overrun when full.
module receiver (
    input  logic      clk,
    input  logic      reset,
    receiver_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shreg_q, shreg_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       finish;
    logic       push;
    logic       ovr_set;
    logic       rx_p0, rx_p1;
    logic       rx_s;
    logic       last_bit;
    logic       par_en;
    logic [9:0] data_q;
    logic       wr_en_q;
    logic       overrun_q;

    assign rx_s     = rx_p1;
    assign last_bit = bus.size ? (bit_idx_q == 3'd7) : (bit_idx_q == 3'd6);
    assign par_en   = (bus.parity == 2'b01) || (bus.parity == 2'b10);
    assign push     = finish & ~bus.full;
    assign ovr_set  = finish & bus.full;

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= bus.rx;
            rx_p1 <= rx_p0;
        end
    end

    // Frame FSM next-state: every action happens on a brgen tick
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        finish    = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (bus.brgen) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = 4'd0;
                    end
                end
                START: begin
                    if (cnt_q == 4'd7) begin
                        cnt_d = 4'd0;
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            bit_idx_d = 3'd0;
                            shreg_d   = 8'd0;
                            pe_d      = 1'b0;
                            fe_d      = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == 4'd15) begin
                        cnt_d              = 4'd0;
                        shreg_d[bit_idx_q] = rx_s;
                        if (last_bit) begin
                            state_d = par_en ? PARITY : STOP1;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                PARITY: begin
                    if (cnt_q == 4'd15) begin
                        cnt_d   = 4'd0;
                        // Unused char[7] is zero at 7 bits, so it never disturbs the XOR
                        pe_d    = (bus.parity == 2'b01) ? (^shreg_q ^ rx_s)
                                                        : ~(^shreg_q ^ rx_s);
                        state_d = STOP1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                STOP1: begin
                    if (cnt_q == 4'd15) begin
                        cnt_d = 4'd0;
                        fe_d  = ~rx_s;
                        if (bus.stop2) begin
                            state_d = STOP2;
                        end else begin
                            state_d = IDLE;
                            finish  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                STOP2: begin
                    if (cnt_q == 4'd15) begin
                        cnt_d   = 4'd0;
                        fe_d    = fe_q | ~rx_s;
                        state_d = IDLE;
                        finish  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // State, frame registers, FIFO push and sticky overrun
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'd0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            data_q    <= 10'd0;
            wr_en_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            wr_en_q   <= push;
            if (push) begin
                data_q <= {fe_d, pe_q, shreg_q};
            end
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_ovr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.data    = data_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.overrun = overrun_q;
    assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for the UART receiver: scoreboard of expected FIFO pushes.
module tb_receiver;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   tick_ctr;
    logic [9:0] exp_q[$];

    receiver_if bus ();

    receiver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // brgen: one clk pulse every 4 clk
    initial begin
        tick_ctr  = 0;
        bus.brgen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_ctr  = tick_ctr + 1;
            bus.brgen = (tick_ctr % 4 == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bit time = 16 ticks = 64 clk
    task automatic drive_bit(input logic b);
        bus.rx = b;
        repeat (64) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] ch, input int nbits, input logic has_par,
                              input logic par_bit, input int nstop, input logic stop_val);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(ch[i]);
        if (has_par) drive_bit(par_bit);
        for (int i = 0; i < nstop; i++) drive_bit(stop_val);
    endtask

    // Scoreboard: every push must match the oldest expected entry
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("push_expected", exp_q.size(), 1);
            end else begin
                check("push_data", bus.data, exp_q.pop_front());
            end
        end
    end

    // Hang guard
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] c;
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b0;
        bus.enable  = 1'b1;
        bus.rx      = 1'b1;
        bus.size    = 1'b1;
        bus.stop2   = 1'b0;
        bus.parity  = 2'b00;
        bus.full    = 1'b0;
        bus.clr_ovr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_data", bus.data, 10'h000);
        check("rst_wr_en", bus.wr_en, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        reset = 1'b1;
        drive_bit(1'b1);

        // 8N1 0x55
        exp_q.push_back(10'h055);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b1);
        drive_bit(1'b1);
        check("8n1_drained", exp_q.size(), 0);
        check("8n1_overrun", bus.overrun, 1'b0);
        check("8n1_busy", bus.busy, 1'b0);

        // 8E1 0xA3 with wrong parity bit (correct would be 0)
        bus.parity = 2'b01;
        c = 8'hA3;
        exp_q.push_back(10'h1A3);
        send_frame(c, 8, 1'b1, ~(^c), 1, 1'b1);
        drive_bit(1'b1);
        check("8e1_drained", exp_q.size(), 0);

        // 7O1 0x41, correct odd parity, stop bit 0
        bus.parity = 2'b10;
        bus.size   = 1'b0;
        c = 8'h41;
        exp_q.push_back(10'h241);
        send_frame(c, 7, 1'b1, ~(^c[6:0]), 1, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("fe_drained", exp_q.size(), 0);
        check("fe_busy", bus.busy, 1'b0);

        // Glitch: low for 4 ticks then high
        bus.parity = 2'b00;
        bus.size   = 1'b1;
        bus.rx     = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("glitch_busy_hi", bus.busy, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.rx = 1'b1;
        repeat (28) @(posedge clk);
        #1;
        check("glitch_busy_lo", bus.busy, 1'b0);
        drive_bit(1'b1);

        // Overrun: FIFO full, then clear
        bus.full = 1'b1;
        send_frame(8'h12, 8, 1'b0, 1'b0, 1, 1'b1);
        drive_bit(1'b1);
        check("ovr_set", bus.overrun, 1'b1);
        check("ovr_data_held", bus.data, 10'h241);
        bus.full    = 1'b0;
        bus.clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_ovr = 1'b0;
        check("ovr_clr", bus.overrun, 1'b0);

        // Enable drop mid-frame discards it
        drive_bit(1'b0);
        drive_bit(1'b0);
        check("en_busy_hi", bus.busy, 1'b1);
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        check("en_busy_lo", bus.busy, 1'b0);
        bus.rx = 1'b1;
        drive_bit(1'b1);
        bus.enable = 1'b1;
        drive_bit(1'b1);

        // 8N2 back-to-back
        bus.stop2 = 1'b1;
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h0FE);
        send_frame(8'h01, 8, 1'b0, 1'b0, 2, 1'b1);
        send_frame(8'hFE, 8, 1'b0, 1'b0, 2, 1'b1);
        drive_bit(1'b1);
        check("b2b_drained", exp_q.size(), 0);

        // Third frame aborted by reset
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_data", bus.data, 10'h000);
        check("mid_rst_wr_en", bus.wr_en, 1'b0);
        check("mid_rst_overrun", bus.overrun, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        bus.rx = 1'b1;
        reset  = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
